// File: rtl/d_arb_pkg.sv
// Shared types and defaults for the two-master data-side arbiter.
package d_arb_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam int          ADDR_LEN_DEF = 14;
  localparam int          TIMEOUT_DEF  = 15;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
  localparam int          CNT_W        = $clog2(TIMEOUT_DEF + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} d_arb_state_t;

  // One master's request bundle, sized for the default bus widths.
  typedef struct packed {
    logic [ADDR_LEN_DEF-1:0] addr;
    logic                    rd;
    logic                    wr;
    logic [XLEN_DEF/8-1:0]   be;
    logic [XLEN_DEF-1:0]     wdata;
  } mreq_t;

  function automatic int cnt_w(input int t);
    return $clog2(t + 1);
  endfunction

endpackage

// File: rtl/d_arb_rr.sv
// Two-way round-robin pick: on a tie the master that did not finish last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt
);
  always_comb begin
    gnt = req[1];
    if (req == 2'b11) gnt = ~last;
  end
endmodule

// File: rtl/d_arb.sv
// Arbitrates the core LSU port and the debug/loader port onto one data port,
// one transaction at a time, with a per-transaction response timeout.
module d_arb
  import d_arb_pkg::*;
#(
  parameter int               XLEN     = XLEN_DEF,
  parameter int               ADDR_LEN = ADDR_LEN_DEF,
  parameter int               TIMEOUT  = TIMEOUT_DEF,
  parameter logic [XLEN-1:0]  ERR_DATA = ERR_DATA_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_LEN-1:0] m0_addr,
  input  logic                m0_rd_req,
  input  logic                m0_wr_req,
  input  logic [XLEN/8-1:0]   m0_be,
  input  logic [XLEN-1:0]     m0_wr_data,
  output logic                m0_rd_ready,
  output logic                m0_wr_ready,
  output logic [XLEN-1:0]     m0_rd_data,
  input  logic [ADDR_LEN-1:0] m1_addr,
  input  logic                m1_rd_req,
  input  logic                m1_wr_req,
  input  logic [XLEN/8-1:0]   m1_be,
  input  logic [XLEN-1:0]     m1_wr_data,
  output logic                m1_rd_ready,
  output logic                m1_wr_ready,
  output logic [XLEN-1:0]     m1_rd_data,
  output logic [ADDR_LEN-1:0] addr,
  output logic                rd_req,
  output logic                wr_req,
  output logic [XLEN/8-1:0]   be,
  output logic [XLEN-1:0]     wr_data,
  input  logic [XLEN-1:0]     rd_data,
  input  logic                rd_ready,
  input  logic                wr_ready,
  output logic                err_timeout,
  output logic                err_owner,
  input  logic                err_clr
);

  localparam int CW = cnt_w(TIMEOUT);

  d_arb_state_t  state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic          typ_wr_q, typ_wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          own_q, own_d;

  mreq_t      mq [2];
  mreq_t      sel;
  logic [1:0] req;
  logic       pick;
  logic       busy, live, hit, done, tmo, fin;
  logic [XLEN-1:0] rdata;

  assign mq[0] = '{m0_addr, m0_rd_req, m0_wr_req, m0_be, m0_wr_data};
  assign mq[1] = '{m1_addr, m1_rd_req, m1_wr_req, m1_be, m1_wr_data};
  assign req   = {mq[1].rd | mq[1].wr, mq[0].rd | mq[0].wr};

  rr_arb2 u_rr (.req(req), .last(last_q), .gnt(pick));

  // Everything downstream follows the granted master; the type is the one
  // latched at grant time, so a mid-transaction rd/wr flip is ignored.
  always_comb begin
    sel   = mq[grant_q];
    busy  = (state_q == BUSY);
    live  = busy & (sel.rd | sel.wr);
    hit   = typ_wr_q ? wr_ready : rd_ready;
    done  = live & hit;
    tmo   = live & ~hit & (cnt_q == CW'(TIMEOUT - 1));
    fin   = done | tmo;
    rdata = tmo ? ERR_DATA : rd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      typ_wr_q <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      own_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      typ_wr_q <= typ_wr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      own_q    <= own_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    typ_wr_d = typ_wr_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: if (|req) begin
        state_d  = BUSY;
        grant_d  = pick;
        typ_wr_d = mq[pick].wr;
        cnt_d    = '0;
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // An abort leaves last untouched so the fairness order is kept.
        if (!live) begin
          state_d = IDLE;
        end else if (fin) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
    err_d = tmo | (err_q & ~err_clr);
    own_d = tmo ? grant_q : own_q;
  end

  always_comb begin
    addr        = '0;
    be          = '0;
    wr_data     = '0;
    rd_req      = 1'b0;
    wr_req      = 1'b0;
    m0_rd_ready = 1'b0;
    m0_wr_ready = 1'b0;
    m1_rd_ready = 1'b0;
    m1_wr_ready = 1'b0;
    m0_rd_data  = '0;
    m1_rd_data  = '0;
    if (busy) begin
      addr    = sel.addr;
      be      = sel.be;
      wr_data = sel.wdata;
      rd_req  = live & ~typ_wr_q;
      wr_req  = live & typ_wr_q;
      if (grant_q) begin
        m1_rd_ready = fin & ~typ_wr_q;
        m1_wr_ready = fin & typ_wr_q;
        m1_rd_data  = typ_wr_q ? '0 : rdata;
      end else begin
        m0_rd_ready = fin & ~typ_wr_q;
        m0_wr_ready = fin & typ_wr_q;
        m0_rd_data  = typ_wr_q ? '0 : rdata;
      end
    end
    err_timeout = err_q;
    err_owner   = own_q;
  end

endmodule

// File: tb/tb_d_arb.sv
// Bench for d_arb: directed scenarios plus random traffic, all checked each
// cycle against a transaction-level model of the arbiter.
module tb_d_arb;
  localparam int AW = 14;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0] a_addr [2];
  logic          a_rd [2], a_wr [2];
  logic [3:0]    a_be [2];
  logic [31:0]   a_wd [2];
  logic [31:0]   rd_data;
  logic          rd_ready, wr_ready, err_clr;

  logic          m0_rd_ready, m0_wr_ready, m1_rd_ready, m1_wr_ready;
  logic [31:0]   m0_rd_data, m1_rd_data, wr_data;
  logic [AW-1:0] addr;
  logic          rd_req, wr_req, err_timeout, err_owner;
  logic [3:0]    be;

  d_arb dut (
    .clk(clk), .rst(rst),
    .m0_addr(a_addr[0]), .m0_rd_req(a_rd[0]), .m0_wr_req(a_wr[0]), .m0_be(a_be[0]),
    .m0_wr_data(a_wd[0]), .m0_rd_ready(m0_rd_ready), .m0_wr_ready(m0_wr_ready),
    .m0_rd_data(m0_rd_data),
    .m1_addr(a_addr[1]), .m1_rd_req(a_rd[1]), .m1_wr_req(a_wr[1]), .m1_be(a_be[1]),
    .m1_wr_data(a_wd[1]), .m1_rd_ready(m1_rd_ready), .m1_wr_ready(m1_wr_ready),
    .m1_rd_data(m1_rd_data),
    .addr(addr), .rd_req(rd_req), .wr_req(wr_req), .be(be), .wr_data(wr_data),
    .rd_data(rd_data), .rd_ready(rd_ready), .wr_ready(wr_ready),
    .err_timeout(err_timeout), .err_owner(err_owner), .err_clr(err_clr)
  );

  int n_cmp = 0, n_bad = 0;

  // Model: the transaction in flight (owner, kind, age) plus fairness/error state.
  bit t_busy, t_who, t_wr, t_last, t_err, t_eown;
  int t_age;

  logic [AW-1:0] e_addr;
  logic [3:0]    e_be;
  logic [31:0]   e_wd, e_rdata;
  logic          e_rdq, e_wrq, e_still, e_tmo, e_fin;
  logic [1:0]    e_rr, e_wrr;
  bit            got [2];
  bit            pend [2];
  bit            stuck;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] ev);
    n_cmp++;
    if (act !== ev) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, ev, $time);
    end
  endtask

  task automatic model_reset();
    t_busy = 0; t_who = 0; t_wr = 0; t_last = 1; t_err = 0; t_eown = 0; t_age = 0;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      a_addr[i] = '0; a_rd[i] = 0; a_wr[i] = 0; a_be[i] = '0; a_wd[i] = '0; pend[i] = 0;
    end
    rd_data = '0; rd_ready = 0; wr_ready = 0; err_clr = 0;
  endtask

  // Expected outputs for this cycle, then compare every output.
  task automatic step_check();
    bit g, hit;
    @(negedge clk);
    e_addr = '0; e_be = '0; e_wd = '0; e_rdata = '0; e_rdq = 0; e_wrq = 0;
    e_still = 0; e_tmo = 0; e_fin = 0; e_rr = '0; e_wrr = '0;
    if (t_busy) begin
      g = t_who;
      e_still = a_rd[g] | a_wr[g];
      e_addr = a_addr[g]; e_be = a_be[g]; e_wd = a_wd[g];
      e_rdq = e_still & !t_wr;
      e_wrq = e_still & t_wr;
      hit = t_wr ? wr_ready : rd_ready;
      e_tmo = e_still && !hit && (t_age == TIMEOUT - 1);
      e_fin = (e_still && hit) || e_tmo;
      if (e_fin) begin
        if (t_wr) e_wrr[g] = 1'b1; else e_rr[g] = 1'b1;
      end
      e_rdata = e_tmo ? 32'hDEAD_BEEF : rd_data;
    end
    cmp("addr", addr, e_addr);
    cmp("be", be, e_be);
    cmp("wr_data", wr_data, e_wd);
    cmp("rd_req", rd_req, e_rdq);
    cmp("wr_req", wr_req, e_wrq);
    cmp("m0_rd_ready", m0_rd_ready, e_rr[0]);
    cmp("m1_rd_ready", m1_rd_ready, e_rr[1]);
    cmp("m0_wr_ready", m0_wr_ready, e_wrr[0]);
    cmp("m1_wr_ready", m1_wr_ready, e_wrr[1]);
    if (e_rr[0]) cmp("m0_rd_data", m0_rd_data, e_rdata);
    if (e_rr[1]) cmp("m1_rd_data", m1_rd_data, e_rdata);
    cmp("err_timeout", err_timeout, t_err);
    cmp("err_owner", err_owner, t_eown);
    got[0] = m0_rd_ready | m0_wr_ready;
    got[1] = m1_rd_ready | m1_wr_ready;
  endtask

  // Advance the model across the clock edge using this cycle's inputs.
  task automatic step_adv();
    bit r0, r1;
    @(posedge clk);
    if (e_tmo) begin t_err = 1; t_eown = t_who; end
    else if (err_clr) t_err = 0;
    if (!t_busy) begin
      r0 = a_rd[0] | a_wr[0];
      r1 = a_rd[1] | a_wr[1];
      if (r0 || r1) begin
        t_who = (r0 && r1) ? !t_last : r1;
        t_wr = a_wr[t_who];
        t_busy = 1; t_age = 0;
      end
    end else begin
      t_age++;
      if (!e_still || e_fin) begin
        t_busy = 0;
        if (e_fin) t_last = t_who;
      end
    end
    #1;
  endtask

  task automatic cyc();
    step_check();
    step_adv();
  endtask

  task automatic do_reset();
    rst = 1; clear_inputs(); model_reset();
    step_check();
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic rand_stim();
    for (int i = 0; i < 2; i++) begin
      if (pend[i] && (got[i] || $urandom_range(0, 39) == 0)) begin
        pend[i] = 0; a_rd[i] = 0; a_wr[i] = 0;
      end else if (pend[i] && $urandom_range(0, 29) == 0) begin
        a_rd[i] = !a_rd[i];
        if (!a_rd[i] && !a_wr[i]) a_wr[i] = 1;
      end else if (!pend[i] && $urandom_range(0, 2) == 0) begin
        pend[i] = 1;
        case ($urandom_range(0, 2))
          0: begin a_rd[i] = 1; a_wr[i] = 0; end
          1: begin a_rd[i] = 0; a_wr[i] = 1; end
          default: begin a_rd[i] = 1; a_wr[i] = 1; end
        endcase
        a_addr[i] = AW'($urandom);
        a_be[i] = 4'($urandom);
        a_wd[i] = $urandom;
      end
    end
    if ($urandom_range(0, 199) == 0) stuck = !stuck;
    rd_ready = !stuck && ($urandom_range(0, 3) == 0);
    wr_ready = !stuck && ($urandom_range(0, 3) == 0);
    rd_data = $urandom;
    err_clr = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    int found, seq [$];
    rst = 1; clear_inputs(); model_reset();
    #2;
    step_check();
    cmp("reset_err_timeout", err_timeout, 1'b0);
    cmp("reset_rd_req", rd_req, 1'b0);
    @(posedge clk); #1; rst = 0;

    // Single read from master 0.
    a_rd[0] = 1; a_addr[0] = 14'h2004;
    step_check(); cmp("t1_idle_rd_req", rd_req, 1'b0); step_adv();
    step_check(); cmp("t1_busy_addr", addr, 14'h2004); step_adv();
    rd_ready = 1; rd_data = 32'h1234_5678;
    step_check();
    cmp("t1_m0_rd_ready", m0_rd_ready, 1'b1);
    cmp("t1_m0_rd_data", m0_rd_data, 32'h1234_5678);
    cmp("t1_m1_rd_ready", m1_rd_ready, 1'b0);
    step_adv();
    a_rd[0] = 0; rd_ready = 0;
    step_check(); cmp("t1_back_idle", rd_req, 1'b0); step_adv();

    // Contention right after reset: alternation starting with master 0.
    do_reset();
    a_wr[0] = 1; a_rd[1] = 1; rd_ready = 1; wr_ready = 1;
    for (int i = 0; i < 8; i++) begin
      step_check();
      if (m0_wr_ready) seq.push_back(0);
      if (m1_rd_ready) seq.push_back(1);
      step_adv();
    end
    cmp("t2_count", seq.size(), 4);
    for (int i = 0; i < 4 && i < seq.size(); i++) cmp("t2_order", seq[i], i % 2);
    clear_inputs(); cyc(); cyc();

    // Timeout on a master 1 read.
    a_rd[1] = 1; found = -1;
    for (int i = 0; i < 30 && found < 0; i++) begin
      step_check();
      if (m1_rd_ready) begin
        found = i;
        cmp("t3_err_data", m1_rd_data, 32'hDEAD_BEEF);
      end
      step_adv();
    end
    a_rd[1] = 0;
    cmp("t3_timeout_cycle", found, 15);
    step_check();
    cmp("t3_err_timeout", err_timeout, 1'b1);
    cmp("t3_err_owner", err_owner, 1'b1);
    step_adv();
    err_clr = 1; cyc(); err_clr = 0;
    step_check(); cmp("t3_err_cleared", err_timeout, 1'b0); step_adv();

    // Abort by master 0 must not disturb the round-robin order.
    a_rd[0] = 1; cyc(); cyc();
    a_rd[0] = 0; cyc();
    step_check();
    cmp("t4_rd_req_dropped", rd_req, 1'b0);
    cmp("t4_no_ready", m0_rd_ready, 1'b0);
    step_adv();
    a_rd[0] = 1; a_rd[1] = 1; rd_ready = 1; found = -1;
    for (int i = 0; i < 6 && found < 0; i++) begin
      step_check();
      if (m0_rd_ready) found = 0;
      else if (m1_rd_ready) found = 1;
      step_adv();
    end
    cmp("t4_next_winner", found, 0);
    clear_inputs(); cyc(); cyc();

    // Read and write together: the write wins.
    a_rd[0] = 1; a_wr[0] = 1; a_be[0] = 4'b0011; cyc();
    step_check();
    cmp("t5_wr_req", wr_req, 1'b1);
    cmp("t5_rd_req", rd_req, 1'b0);
    cmp("t5_be", be, 4'b0011);
    step_adv();
    rd_ready = 1; wr_ready = 1;
    step_check();
    cmp("t5_wr_ready", m0_wr_ready, 1'b1);
    cmp("t5_rd_ready", m0_rd_ready, 1'b0);
    step_adv();
    clear_inputs(); cyc();

    // Asynchronous reset in the middle of a transaction.
    a_rd[0] = 1; cyc();
    step_check();
    #1; rst = 1; rd_ready = 1;
    #1;
    cmp("t6_rd_req", rd_req, 1'b0);
    cmp("t6_m0_rd_ready", m0_rd_ready, 1'b0);
    cmp("t6_wr_req", wr_req, 1'b0);
    model_reset();
    @(posedge clk); #1;
    rst = 0; clear_inputs();
    a_rd[0] = 1; a_rd[1] = 1; rd_ready = 1; found = -1;
    for (int i = 0; i < 6 && found < 0; i++) begin
      step_check();
      if (m0_rd_ready) found = 0;
      else if (m1_rd_ready) found = 1;
      step_adv();
    end
    cmp("t6_first_winner", found, 0);
    clear_inputs(); cyc(); cyc();

    // Random traffic.
    stuck = 0;
    for (int i = 0; i < 4000; i++) begin
      step_check();
      step_adv();
      rand_stim();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/d_arb.md
Name: d_arb

Overview:
Two-master arbiter placed in front of the data-side address mux, d_mux. Master 0 is the core load/store port. Master 1 is the debug/program-loader port. The block sequences one transaction at a time onto the single downstream data port, using round-robin priority and a per-transaction response timeout. It returns the downstream ready and read data only to the granted master.

Parameters:
XLEN, 32, data width
ADDR_LEN, 14, byte-address width
TIMEOUT, 15, max BUSY cycles before forced completion; range 1..255
ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
mN_addr  in  ADDR_LEN  master N byte address (N=0,1; the mN_ ports below exist for both masters)
mN_rd_req  in  1  read request, level, held until ready
mN_wr_req  in  1  write request, level, held until ready
mN_be  in  XLEN/8  byte enables
mN_wr_data  in  XLEN  write data
mN_rd_ready  out  1  read completion pulse
mN_wr_ready  out  1  write completion pulse
mN_rd_data  out  XLEN  read data, valid when mN_rd_ready=1
addr  out  ADDR_LEN  downstream address
rd_req  out  1  downstream read request
wr_req  out  1  downstream write request
be  out  XLEN/8  downstream byte enables
wr_data  out  XLEN  downstream write data
rd_data  in  XLEN  downstream read data
rd_ready  in  1  downstream read ready
wr_ready  in  1  downstream write ready
err_timeout  out  1  sticky timeout flag
err_owner  out  1  master that timed out last
err_clr  in  1  clears err_timeout

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state=IDLE, grant=0, last=1 (so master 0 wins the first tie), cnt=0.
  - err_timeout=0, err_owner=0.
  - All *_ready outputs and rd_req/wr_req are 0.
  - addr, be and wr_data are 0.
  - mN_rd_data is 0.
- Master request: reqN = mN_rd_req | mN_wr_req. If both rd and wr are high on one master, write wins and rd is masked for that transaction.
- FSM states: IDLE, BUSY.
- IDLE:
  - No downstream request is driven.
  - If only one reqN is high, grant=N.
  - If both are high, grant = ~last (round-robin).
  - Any request moves the FSM to BUSY next cycle and clears cnt.
  - Arbitration costs one cycle.
- BUSY:
  - addr, be, wr_data and the masked rd_req/wr_req are muxed combinationally from the granted master.
  - The ungranted master's ready outputs stay 0.
  - cnt increments every cycle.
- Completion:
  - In BUSY, if the downstream ready matching the active type (rd_ready for a read, wr_ready for a write) is 1, the matching mG_*_ready=1 in the same cycle.
  - mG_rd_data = rd_data, passed combinationally.
  - Next cycle: last=grant, state=IDLE.
  - Back-to-back requests from one master therefore cost 1 idle cycle each.
- Timeout:
  - In BUSY, if cnt==TIMEOUT-1 with no matching ready, force mG_*_ready=1.
  - mG_rd_data = ERR_DATA for reads. Writes are dropped.
  - Set err_timeout=1 and err_owner=grant. Go to IDLE with last=grant.
- Abort: if the granted master drops both requests while in BUSY, drive no ready pulse and return to IDLE next cycle. last is unchanged.
- Type change while BUSY: ignored. The type is latched on the IDLE→BUSY transition.
- Stray downstream ready in IDLE: ignored.
- Ready for the wrong type in BUSY: ignored; counting continues.
- err_clr: clears err_timeout next cycle. If err_clr coincides with a timeout event, set wins.
- Reset mid-transaction: all outputs drop asynchronously and the FSM returns to IDLE. No ready is emitted.

Decomposition:
- Shared package (d_arb_pkg):
  - typedef enum logic {IDLE, BUSY} d_arb_state_t
  - localparam CNT_W = $clog2(TIMEOUT+1)
  - typedef struct for a master request bundle: addr, rd, wr, be, wdata
  - ERR_DATA default constant
- Sub-module: rr_arb2, the 2-way round-robin pick: req[1:0], last → gnt.

Test Plan:
- Single read, master 0 only: m0_rd_req at cycle 0, addr=14'h2004, downstream rd_ready at cycle 2 with rd_data=32'h1234_5678 → m0_rd_ready=1 at cycle 2, m0_rd_data=32'h1234_5678, m1 outputs 0, FSM back in IDLE at cycle 3.
- Simultaneous requests after reset: m0 write and m1 read both held → m0 granted first (last=1 at reset), then m1. Grant alternates 0,1,0,1 over 4 transactions while both requests stay high.
- Timeout: m1 read with rd_ready tied 0, TIMEOUT=15 → m1_rd_ready=1 on the 15th BUSY cycle, m1_rd_data=32'hDEAD_BEEF, err_timeout=1, err_owner=1. err_clr pulse → err_timeout=0 next cycle.
- Abort: m0 read granted, m0_rd_req dropped on the 2nd BUSY cycle → rd_req=0 next cycle, no m0_rd_ready, grant order unchanged on the next contention.
- rd+wr both high on m0 with be=4'b0011 → downstream wr_req=1, rd_req=0, be=4'b0011. Completion arrives on m0_wr_ready only.
- Async reset asserted mid-BUSY → rd_req, wr_req and all ready outputs are 0 immediately. After release, state is IDLE and master 0 wins the first tie.
